// File: rtl/npu_param_loader.sv
// Host-to-NPU loader: fills image banks, then conv/dense/bias weight RAMs, from one valid/ready word stream.
// Optional NPU_LOADER_PACKED_EN: weight regions take LANES bytes per host word instead of one.
module npu_param_loader #(
   parameter int LANES       = 4,
   parameter int IMG_WORDS   = 225,
   parameter int CONV_BYTES  = 18816,
   parameter int DENSE_BYTES = 16746,
   parameter int BIAS_BYTES  = 10,
   parameter int IMG_AW      = 10,
   parameter int WAW         = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 wr_valid,
   input  logic [8*LANES-1:0]   wr_data,
   output logic                 wr_ready,
   output logic [LANES-1:0]     img_wren,
   output logic [8*LANES-1:0]   img_data,
   output logic [IMG_AW-1:0]    img_addr,
   output logic                 conv_wren,
   output logic                 dense_wren,
   output logic                 bias_wren,
   output logic [7:0]           wt_data,
   output logic [WAW-1:0]       conv_addr,
   output logic [WAW-1:0]       dense_addr,
   output logic [WAW-1:0]       bias_addr,
   output logic                 busy,
   output logic                 done
);

   localparam int MAX_AB = (IMG_WORDS > CONV_BYTES) ? IMG_WORDS : CONV_BYTES;
   localparam int MAX_CD = (DENSE_BYTES > BIAS_BYTES) ? DENSE_BYTES : BIAS_BYTES;
   localparam int MAX_SZ = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = $clog2(MAX_SZ) + 1;

   if (IMG_WORDS < 1 || CONV_BYTES < 1 || DENSE_BYTES < 1 || BIAS_BYTES < 1) begin : g_size_chk
      $error("npu_param_loader: every region size must be at least 1");
   end

   typedef enum logic [2:0] {S_IDLE, S_IMG, S_CONV, S_DENSE, S_BIAS, S_DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_start_q;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_size_m1;
   logic            w_start_edge, w_accept, w_wt_state;
   logic            w_emit, w_step, w_last;
   logic [7:0]      w_byte;
   logic            w_busy_nxt, w_rdy_nxt;

   logic [LANES-1:0]   w_img_wren;
   logic [8*LANES-1:0] w_img_data;
   logic [IMG_AW-1:0]  w_img_addr;
   logic               w_conv_wren, w_dense_wren, w_bias_wren;
   logic [7:0]         w_wt_data;
   logic [WAW-1:0]     w_conv_addr, w_dense_addr, w_bias_addr;

   assign w_start_edge = start & ~r_start_q;
   assign w_accept     = wr_valid & wr_ready;
   assign w_wt_state   = (r_state == S_CONV) || (r_state == S_DENSE) || (r_state == S_BIAS);

   always_comb begin
      w_size_m1 = '0;
      case (r_state)
         S_IMG:   w_size_m1 = CW'(IMG_WORDS - 1);
         S_CONV:  w_size_m1 = CW'(CONV_BYTES - 1);
         S_DENSE: w_size_m1 = CW'(DENSE_BYTES - 1);
         S_BIAS:  w_size_m1 = CW'(BIAS_BYTES - 1);
         default: w_size_m1 = '0;
      endcase
   end

   assign w_step = (r_state == S_IMG) ? w_accept : w_emit;
   assign w_last = w_step && (r_cnt == w_size_m1);

`ifdef NPU_LOADER_PACKED_EN
   localparam int LW = $clog2(LANES) + 1;

   logic [8*LANES-1:0] r_sh;
   logic [LW-1:0]      r_left, w_left_nxt;
   logic               r_drop, w_drop_nxt;

   // Byte 0 goes out with the accepted word; the rest drain from the shift register.
   always_comb begin
      w_emit = 1'b0;
      w_byte = wr_data[7:0];
      if (w_wt_state) begin
         if (w_accept) begin
            w_emit = 1'b1;
         end else if (r_left != '0 && !r_drop) begin
            w_emit = 1'b1;
            w_byte = r_sh[7:0];
         end
      end
   end

   // Bytes left over when a region ends still occupy their slots but are not written.
   always_comb begin
      w_left_nxt = r_left;
      w_drop_nxt = r_drop;
      if (r_state == S_IDLE) begin
         w_left_nxt = '0;
         w_drop_nxt = 1'b0;
      end else if (w_accept && w_wt_state) begin
         w_left_nxt = LW'(LANES - 1);
         w_drop_nxt = w_last;
      end else if (r_left != '0) begin
         w_left_nxt = r_left - 1'b1;
         if (w_last) w_drop_nxt = 1'b1;
      end
      if (w_left_nxt == '0) w_drop_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sh   <= '0;
         r_left <= '0;
         r_drop <= 1'b0;
      end else begin
         if (w_accept && w_wt_state) r_sh <= wr_data >> 8;
         else if (r_left != '0)      r_sh <= r_sh >> 8;
         r_left <= w_left_nxt;
         r_drop <= w_drop_nxt;
      end
   end

   assign w_rdy_nxt = w_busy_nxt && (w_left_nxt == '0);
`else
   always_comb begin
      w_emit = w_wt_state && w_accept;
      w_byte = wr_data[7:0];
   end

   assign w_rdy_nxt = w_busy_nxt;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_start_q <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_start_q <= start;
         if (w_state_nxt != r_state) r_cnt <= '0;
         else if (w_step)            r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_edge) w_state_nxt = S_IMG;
         S_IMG:   if (w_last)       w_state_nxt = S_CONV;
         S_CONV:  if (w_last)       w_state_nxt = S_DENSE;
         S_DENSE: if (w_last)       w_state_nxt = S_BIAS;
         S_BIAS:  if (w_last)       w_state_nxt = S_DONE;
         S_DONE:  if (!start)       w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   assign w_busy_nxt = (w_state_nxt == S_IMG) || (w_state_nxt == S_CONV) ||
                       (w_state_nxt == S_DENSE) || (w_state_nxt == S_BIAS);

   always_comb begin
      w_img_wren   = '0;
      w_img_data   = '0;
      w_img_addr   = '0;
      w_conv_wren  = 1'b0;
      w_dense_wren = 1'b0;
      w_bias_wren  = 1'b0;
      w_wt_data    = '0;
      w_conv_addr  = '0;
      w_dense_addr = '0;
      w_bias_addr  = '0;
      if (r_state == S_IMG && w_accept) begin
         w_img_wren = '1;
         w_img_data = wr_data;
         w_img_addr = IMG_AW'(r_cnt);
      end
      if (w_emit) begin
         w_wt_data = w_byte;
         case (r_state)
            S_CONV:  begin w_conv_wren  = 1'b1; w_conv_addr  = WAW'(r_cnt); end
            S_DENSE: begin w_dense_wren = 1'b1; w_dense_addr = WAW'(r_cnt); end
            S_BIAS:  begin w_bias_wren  = 1'b1; w_bias_addr  = WAW'(r_cnt); end
            default: w_wt_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ready   <= 1'b0;
         img_wren   <= '0;
         img_data   <= '0;
         img_addr   <= '0;
         conv_wren  <= 1'b0;
         dense_wren <= 1'b0;
         bias_wren  <= 1'b0;
         wt_data    <= '0;
         conv_addr  <= '0;
         dense_addr <= '0;
         bias_addr  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         wr_ready   <= w_rdy_nxt;
         img_wren   <= w_img_wren;
         img_data   <= w_img_data;
         img_addr   <= w_img_addr;
         conv_wren  <= w_conv_wren;
         dense_wren <= w_dense_wren;
         bias_wren  <= w_bias_wren;
         wt_data    <= w_wt_data;
         conv_addr  <= w_conv_addr;
         dense_addr <= w_dense_addr;
         bias_addr  <= w_bias_addr;
         busy       <= w_busy_nxt;
         done       <= (w_state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_npu_param_loader.sv
// Bench for npu_param_loader: directed and random loads against a byte-stream reference model.
module tb_npu_param_loader;

   localparam int LANES = 4;
   localparam int IMGW  = 3;
   localparam int CONVB = 3;
   localparam int DENSB = 2;
   localparam int BIASB = 2;
`ifdef NPU_LOADER_PACKED_EN
   localparam int BPW = LANES;
`else
   localparam int BPW = 1;
`endif

   logic        clk, reset, start, wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic [3:0]  img_wren;
   logic [31:0] img_data;
   logic [9:0]  img_addr;
   logic        conv_wren, dense_wren, bias_wren, busy, done;
   logic [7:0]  wt_data;
   logic [14:0] conv_addr, dense_addr, bias_addr;

   npu_param_loader #(
      .LANES(LANES), .IMG_WORDS(IMGW), .CONV_BYTES(CONVB), .DENSE_BYTES(DENSB),
      .BIAS_BYTES(BIASB), .IMG_AW(10), .WAW(15)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .img_wren(img_wren), .img_data(img_data), .img_addr(img_addr),
      .conv_wren(conv_wren), .dense_wren(dense_wren), .bias_wren(bias_wren),
      .wt_data(wt_data), .conv_addr(conv_addr), .dense_addr(dense_addr),
      .bias_addr(bias_addr), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [55:0] mon_q[$];
   logic [55:0] exp_q[$];
   logic [31:0] words[16];
   int sizes[4] = '{IMGW, CONVB, DENSB, BIASB};

   // Write record: region kind, address, data, lane mask, busy, done.
   function automatic logic [55:0] mk(input int k, input int a, input logic [31:0] d,
                                      input logic [3:0] m, input logic b, input logic dn);
      return {k[1:0], a[15:0], d, m, b, dn};
   endfunction

   always @(negedge clk) begin
      if (img_wren != 4'b0) mon_q.push_back(mk(0, int'(img_addr), img_data, img_wren, busy, done));
      if (conv_wren)  mon_q.push_back(mk(1, int'(conv_addr),  {24'b0, wt_data}, 4'b0, busy, done));
      if (dense_wren) mon_q.push_back(mk(2, int'(dense_addr), {24'b0, wt_data}, 4'b0, busy, done));
      if (bias_wren)  mon_q.push_back(mk(3, int'(bias_addr),  {24'b0, wt_data}, 4'b0, busy, done));
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] all_out();
      return 128'({wr_ready, busy, done, img_wren, img_data, img_addr, conv_wren, dense_wren,
                   bias_wren, wt_data, conv_addr, dense_addr, bias_addr});
   endfunction

   // Reference: image words go to addr k; each weight region consumes whole words, BPW bytes each,
   // and any bytes of a word beyond the region's end are thrown away.
   task automatic model(output int n_used);
      int idx, b;
      logic [31:0] w;
      logic [55:0] e;
      exp_q = {};
      for (int k = 0; k < IMGW; k++) exp_q.push_back(mk(0, k, words[k], 4'hF, 1'b1, 1'b0));
      idx = IMGW;
      for (int r = 1; r <= 3; r++) begin
         b = 0;
         while (b < sizes[r]) begin
            w = words[idx];
            idx++;
            for (int j = 0; j < BPW && b < sizes[r]; j++) begin
               exp_q.push_back(mk(r, b, {24'b0, w[8*j +: 8]}, 4'b0, 1'b1, 1'b0));
               b++;
            end
         end
      end
      e = exp_q.pop_back();
      e[1:0] = 2'b01;
      exp_q.push_back(e);
      n_used = idx;
   endtask

   // Entered and left at negedge+1; drives n words, optionally idling one cycle after each accept.
   task automatic send_words(input int n, input bit stall);
      bit acc;
      int guard, n0;
      for (int i = 0; i < n; i++) begin
         wr_data  = words[i];
         wr_valid = 1'b1;
         acc = 1'b0;
         guard = 0;
         n0 = 0;
         while (!acc && guard < 64) begin
            acc = wr_ready;
            n0 = mon_q.size();
            @(posedge clk); #1;
            guard++;
            if (!acc) begin @(negedge clk); #1; end
         end
         wr_valid = 1'b0;
         wr_data  = $urandom;
         if (!acc) begin
            chk("accept_timeout", 128'(guard), 128'(0));
            return;
         end
         @(negedge clk); #1;
         chk("write_latency", 128'(mon_q.size()), 128'(n0 + 1));
         if (BPW > 1 && i >= IMGW) begin
            chk("packed_rdy_low", 128'(wr_ready), 128'(0));
            for (int c = 0; c < 2; c++) begin
               @(negedge clk); #1;
               chk("packed_rdy_low", 128'(wr_ready), 128'(0));
            end
         end
         if (stall) begin @(negedge clk); #1; end
      end
   endtask

   task automatic run_load(input bit stall, input bit directed);
      int n;
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      if (directed) begin
         for (int k = 0; k < IMGW; k++) words[k] = 32'h03020100 + k * 32'h04040404;
         words[IMGW]     = 32'h44332211;
         words[IMGW + 1] = 32'h88776655;
      end
      model(n);
      mon_q = {};
      start = 1'b1;
      send_words(n, stall);
      repeat (3) begin @(negedge clk); #1; end
      chk("write_count", 128'(mon_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
         chk("write_rec", 128'(mon_q[i]), 128'(exp_q[i]));
      chk("end_status", 128'({wr_ready, busy, done}), 128'(3'b001));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; wr_valid = 1'b1; wr_data = $urandom;
      repeat (3) begin
         @(negedge clk); #1;
         chk("reset_outputs", all_out(), 128'(0));
      end
      reset = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk); #1;
      chk("idle_outputs", all_out(), 128'(0));

      run_load(1'b0, 1'b1);

      repeat (5) begin
         @(negedge clk); #1;
         chk("hold_done", 128'({wr_ready, busy, done}), 128'(3'b001));
      end
      start = 1'b0;
      @(negedge clk); #1;
      chk("back_to_idle", 128'({wr_ready, busy, done}), 128'(3'b000));

      run_load(1'b1, 1'b0);

      start = 1'b0;
      @(negedge clk); #1;
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      mon_q = {};
      start = 1'b1;
      send_words(IMGW + ((BPW == 1) ? 2 : 1), 1'b0);
      chk("midload_busy", 128'({busy, done}), 128'(2'b10));
      reset = 1'b1; start = 1'b0; wr_valid = 1'b1; wr_data = $urandom;
      repeat (2) begin
         @(negedge clk); #1;
         chk("midload_reset", all_out(), 128'(0));
      end
      reset = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk); #1;
      chk("post_reset_idle", all_out(), 128'(0));

      run_load(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/npu_param_loader.md
# npu_param_loader

Parametrised host-to-NPU memory loader. Accepts a stream of host data words with a valid/ready handshake and fills, in a fixed order, the LANES-wide image bank set, the convolution weight RAM, the dense weight RAM and the dense bias RAM. Each region has an exact, parameter-defined length. The block sits between the host register interface and the NPU on-chip RAMs, and reports busy/done to the control register file.

## Interface
- LANES, 4, number of image bank lanes; host word width is 8*LANES bits
- IMG_WORDS, 225, host words written to the image banks (one byte per lane per word)
- CONV_BYTES, 18816, bytes written to the conv weight RAM
- DENSE_BYTES, 16746, bytes written to the dense weight RAM
- BIAS_BYTES, 10, bytes written to the dense bias RAM
- IMG_AW, 10, image bank address width
- WAW, 15, conv/dense/bias address width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  level request from control register; load begins on a 0->1 edge seen in IDLE
- wr_valid  in  1  host word valid
- wr_data  in  8*LANES  host word; lane i = bits [8i+7:8i]
- wr_ready  out  1  block can accept a word this cycle
- img_wren  out  LANES  per-lane image bank write enable
- img_data  out  8*LANES  per-lane image byte
- img_addr  out  IMG_AW  image bank address, shared by all lanes
- conv_wren, dense_wren, bias_wren  out  1 each  region write enables
- wt_data  out  8  byte for the conv/dense/bias RAMs; these RAMs share the bus, qualified by their wren
- conv_addr, dense_addr, bias_addr  out  WAW each  region addresses
- busy  out  1  high in IMG, CONV, DENSE and BIAS
- done  out  1  high in DONE

## Operation
- States: IDLE, IMG, CONV, DENSE, BIAS, DONE.
- IDLE -> IMG on a rising edge of start. The block keeps a registered copy of start to detect the edge. All region counters clear on this transition.
- A beat is accepted when wr_valid & wr_ready.
- IMG: each accepted word produces one write to all lanes at img_addr = word index (0..IMG_WORDS-1). On the last word the state goes to CONV.
- CONV, DENSE, BIAS (unpacked, default): each accepted word supplies one byte, wr_data[7:0], at addr = byte index. After the last byte of a region the state advances CONV -> DENSE -> BIAS -> DONE.
- DONE -> IDLE when start = 0. Holding start high keeps the block in DONE; re-loading requires start to fall and then rise again.
- wr_ready = 1 in IMG/CONV/DENSE/BIAS (unpacked), 0 in IDLE and DONE.
- Counters are $clog2(max region)+1 bits wide. Terminal compare is count == SIZE-1 on an accepted beat. Addresses never exceed SIZE-1 and never wrap.
- A region size of 0 is illegal (enforce with an elaboration check).
- Data and addresses for writes are never emitted outside their state.

## Timing
- All outputs are registered. Reset value of every output is 0, and state = IDLE.
- Write latency is 1 cycle: the beat accepted at edge N gives wren/data/addr valid for the cycle after edge N. wren is high for exactly one cycle per write.
- The state transition occurs on the same edge as the last accepted beat of a region. The first write of the next region may follow with no bubble.
- busy deasserts and done asserts the cycle after the final BIAS write is issued, which is the same cycle that write's wren is high.
- Reset mid-load aborts immediately: the state goes to IDLE, all counters and outputs return to 0, and a partially loaded region is not resumed.
- A start edge while not in IDLE is ignored.

## Configuration
- NPU_LOADER_PACKED_EN defined: in CONV/DENSE/BIAS, each accepted word is latched into a shift register. Its LANES bytes are emitted one per cycle, lane 0 first, on consecutive cycles. wr_ready is 0 while bytes remain unsent, so each word occupies LANES cycles.
  - If a region ends mid-word, the remaining bytes of that word are discarded and the next region starts on a fresh word.
  - IMG behaviour is unchanged.
- Not defined: one byte per word, as in Operation. The shift register is absent.

## Test plan
Parameters for all tests: LANES=4, IMG_WORDS=3, CONV_BYTES=3, DENSE_BYTES=2, BIAS_BYTES=2.
- Reset check: assert reset for 3 cycles, with wr_valid=1 -> all outputs 0, wr_ready=0, no wren.
- Full unpacked load: start 0->1, then stream 10 words back-to-back. Words 0..2 = 0x03020100+k*0x04040404 -> img_addr 0,1,2 with all four lanes written. Conv addresses 0..2, dense 0..1, bias 0..1, with wt_data equal to the low bytes. done is high after the 10th write; no extra wren.
- Handshake stalls: toggle wr_valid 1/0 each cycle through the load -> writes occur only on accepted beats, addresses are contiguous, total writes = 3 image + 7 byte writes.
- Restart rules: hold start=1 in DONE for 5 cycles -> the block stays in DONE. Drop start, then raise it -> IMG is re-entered with img_addr starting at 0.
- Mid-load reset: assert reset after 2 conv bytes -> IDLE and all outputs 0. A new start edge reloads from img_addr 0.
- Packed mode (NPU_LOADER_PACKED_EN): after IMG, send word 0x44332211 then 0x88776655.
  - Conv gets bytes 0x11,0x22,0x33 at addresses 0..2, and 0x44 is discarded.
  - Dense gets 0x55,0x66, and bias takes the next word.
  - wr_ready is low for 3 cycles after each accepted word.
